// File: rtl/expr_stream_checker.sv
// Streaming validator for ASCII arithmetic expressions, one character per accepted cycle.
// out flags a complete, well-formed prefix; err is sticky until restart or reset.
module expr_stream_checker #(
    parameter int unsigned MAX_DIGITS  = 8,
    parameter int unsigned MAX_DEPTH   = 4,
    parameter logic [3:0]  OP_MASK     = 4'b0101,
    parameter bit          ALLOW_SPACE = 1'b1,
    parameter int unsigned OPC_W       = 8
) (
    input  logic                               clk,
    input  logic                               clr_n,
    input  logic                               restart,
    input  logic                               in_valid,
    input  logic [7:0]                         in,
    output logic                               out,
    output logic                               err,
    output logic [$clog2(MAX_DEPTH+1)-1:0]     depth,
    output logic [OPC_W-1:0]                   op_count
);

    localparam int unsigned DW  = $clog2(MAX_DEPTH + 1);
    localparam int unsigned DCW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_OPND,
        S_NUM,
        S_CLOSED,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             out_q, err_q;

    logic is_dig, is_op, is_lp, is_rp, is_sp;
    logic [OPC_W-1:0] opc_inc;

    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_lp  = (in == 8'h28);
        is_rp  = (in == 8'h29);
        is_sp  = ALLOW_SPACE && (in == 8'h20);
        // A disabled operator falls through as an illegal character.
        case (in)
            8'h2B:   is_op = OP_MASK[0];
            8'h2D:   is_op = OP_MASK[1];
            8'h2A:   is_op = OP_MASK[2];
            8'h2F:   is_op = OP_MASK[3];
            default: is_op = 1'b0;
        endcase
    end

    assign opc_inc = (opc_q == {OPC_W{1'b1}}) ? opc_q : opc_q + 1'b1;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d = state_q;
        dcnt_d  = dcnt_q;
        depth_d = depth_q;
        opc_d   = opc_q;
        if (restart) begin
            state_d = S_OPND;
            dcnt_d  = '0;
            depth_d = '0;
            opc_d   = '0;
        end else if (in_valid) begin
            unique case (state_q)
                S_OPND: begin
                    if (is_dig) begin
                        state_d = S_NUM;
                        dcnt_d  = DCW'(1);
                    end else if (is_lp) begin
                        if (depth_q < DW'(MAX_DEPTH)) depth_d = depth_q + 1'b1;
                        else                          state_d = S_ERR;
                    end else if (!is_sp) begin
                        state_d = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_dig) begin
                        if (dcnt_q < DCW'(MAX_DIGITS)) dcnt_d  = dcnt_q + 1'b1;
                        else                           state_d = S_ERR;
                    end else if (is_op) begin
                        state_d = S_OPND;
                        opc_d   = opc_inc;
                    end else if (is_rp) begin
                        if (depth_q != '0) begin
                            depth_d = depth_q - 1'b1;
                            state_d = S_CLOSED;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (is_sp) begin
                        state_d = S_CLOSED;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_CLOSED: begin
                    if (is_op) begin
                        state_d = S_OPND;
                        opc_d   = opc_inc;
                    end else if (is_rp) begin
                        if (depth_q != '0) depth_d = depth_q - 1'b1;
                        else               state_d = S_ERR;
                    end else if (!is_sp) begin
                        state_d = S_ERR;
                    end
                end
                default: state_d = S_ERR;
            endcase
        end
    end

    // Outputs are registered from the next state so they track the byte just consumed.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_OPND;
            dcnt_q  <= '0;
            depth_q <= '0;
            opc_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            depth_q <= depth_d;
            opc_q   <= opc_d;
            out_q   <= ((state_d == S_NUM) || (state_d == S_CLOSED)) && (depth_d == '0);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign out      = out_q;
    assign err      = err_q;
    assign depth    = depth_q;
    assign op_count = opc_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Directed bench for expr_stream_checker: several parameterisations share one input stream.
module tb_expr_stream_checker;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       restart;
    logic       in_valid;
    logic [7:0] in;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    // Defaults
    logic       def_out, def_err;
    logic [2:0] def_depth;
    logic [7:0] def_opc;
    // MAX_DIGITS=4
    logic       dg_out, dg_err;
    logic [2:0] dg_depth;
    logic [7:0] dg_opc;
    // OP_MASK=1111
    logic       oa_out, oa_err;
    logic [2:0] oa_depth;
    logic [7:0] oa_opc;
    // MAX_DEPTH=2
    logic       d2_out, d2_err;
    logic [1:0] d2_depth;
    logic [7:0] d2_opc;
    // ALLOW_SPACE=0
    logic       ns_out, ns_err;
    logic [2:0] ns_depth;
    logic [7:0] ns_opc;
    // OPC_W=2
    logic       oc_out, oc_err;
    logic [2:0] oc_depth;
    logic [1:0] oc_opc;

    expr_stream_checker u_def (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(def_out), .err(def_err), .depth(def_depth), .op_count(def_opc));

    expr_stream_checker #(.MAX_DIGITS(4)) u_dig4 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(dg_out), .err(dg_err), .depth(dg_depth), .op_count(dg_opc));

    expr_stream_checker #(.OP_MASK(4'b1111)) u_opall (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(oa_out), .err(oa_err), .depth(oa_depth), .op_count(oa_opc));

    expr_stream_checker #(.MAX_DEPTH(2), .ALLOW_SPACE(1'b1)) u_d2 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(d2_out), .err(d2_err), .depth(d2_depth), .op_count(d2_opc));

    expr_stream_checker #(.ALLOW_SPACE(1'b0)) u_nosp (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(ns_out), .err(ns_err), .depth(ns_depth), .op_count(ns_opc));

    expr_stream_checker #(.OPC_W(2)) u_opc2 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in),
        .out(oc_out), .err(oc_err), .depth(oc_depth), .op_count(oc_opc));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one edge; outputs are sampled 1 time unit later.
    task automatic send(input logic [7:0] b);
        in       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic do_restart(input logic v, input logic [7:0] b);
        restart  = 1'b1;
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        string s1, s2, o1, o2, d2s;
        clr_n    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        #12;
        check("reset_out",   def_out,   0);
        check("reset_err",   def_err,   0);
        check("reset_depth", def_depth, 0);
        check("reset_opc",   def_opc,   0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("empty_out", def_out, 0);

        // 1: multi-digit operands with enabled + and *
        s1 = "12+3*4";
        o1 = "110101";
        for (int i = 0; i < s1.len(); i++) begin
            send(s1[i]);
            check($sformatf("t1_out[%0d]", i), def_out, (o1[i] == "1") ? 1 : 0);
            check($sformatf("t1_depth[%0d]", i), def_depth, 0);
        end
        check("t1_err", def_err, 0);
        check("t1_opc", def_opc, 2);

        // 2: parentheses, then an unmatched ')'
        do_restart(1'b0, 8'h00);
        s2  = "(1+2)*3";
        o2  = "0000101";
        d2s = "1111000";
        for (int i = 0; i < s2.len(); i++) begin
            send(s2[i]);
            check($sformatf("t2_out[%0d]", i), def_out, (o2[i] == "1") ? 1 : 0);
            check($sformatf("t2_depth[%0d]", i), def_depth, (d2s[i] == "1") ? 1 : 0);
        end
        send(")");
        check("t2_err",   def_err,   1);
        check("t2_out",   def_out,   0);
        check("t2_depth", def_depth, 0);
        check("t2_opc",   def_opc,   2);

        // 3: digit limit, sticky error, restart discards its byte
        do_restart(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            send(8'h31 + 8'(i));
            check($sformatf("t3_out[%0d]", i), dg_out, 1);
        end
        send("5");
        check("t3_err5", dg_err, 1);
        check("t3_out5", dg_out, 0);
        send("7");
        check("t3_err_sticky", dg_err, 1);
        check("t3_out_sticky", dg_out, 0);
        do_restart(1'b1, "9");
        check("t3_rs_out", dg_out, 0);
        check("t3_rs_err", dg_err, 0);
        send("7");
        check("t3_out7", dg_out, 1);
        check("t3_err7", dg_err, 0);

        // 4: operator mask
        do_restart(1'b0, 8'h00);
        send_str("1-");
        check("t4_def_err_minus", def_err, 1);
        send("2");
        check("t4_def_err", def_err, 1);
        check("t4_def_opc", def_opc, 0);
        check("t4_all_out", oa_out, 1);
        check("t4_all_err", oa_err, 0);
        check("t4_all_opc", oa_opc, 1);

        // 5: depth limit and spaces
        do_restart(1'b0, 8'h00);
        send_str("( ( 1 )");
        check("t5_mid_depth", d2_depth, 1);
        check("t5_mid_out",   d2_out,   0);
        send_str(" )");
        check("t5_out",   d2_out,   1);
        check("t5_depth", d2_depth, 0);
        check("t5_err",   d2_err,   0);
        do_restart(1'b0, 8'h00);
        send_str("((");
        check("t5_lp2_err", d2_err, 0);
        send("(");
        check("t5_lp3_err",   d2_err,   1);
        check("t5_lp3_depth", d2_depth, 2);
        do_restart(1'b0, 8'h00);
        send_str("1 ");
        check("t5_sp_out",   d2_out, 1);
        check("t5_nosp_err", ns_err, 1);
        check("t5_nosp_out", ns_out, 0);
        send("2");
        check("t5_12_err", d2_err, 1);
        check("t5_12_out", d2_out, 0);

        // 6: asynchronous reset between edges, then op_count saturation
        do_restart(1'b0, 8'h00);
        send_str("(1+");
        check("t6_pre_depth", def_depth, 1);
        check("t6_pre_opc",   def_opc,   1);
        #2;
        clr_n = 1'b0;
        #1;
        check("t6_async_out",   def_out,   0);
        check("t6_async_err",   def_err,   0);
        check("t6_async_depth", def_depth, 0);
        check("t6_async_opc",   def_opc,   0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        send("5");
        check("t6_out5", def_out, 1);
        do_restart(1'b0, 8'h00);
        send_str("1+1+1+1+1");
        check("t6_sat_opc", oc_opc, 3);
        check("t6_sat_out", oc_out, 1);
        check("t6_sat_err", oc_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
